clk_div_ctrl: RTL and testbench

Programmable, run-controlled clock divider sequencer. Generates a divided clock `clk_out` and a one-cycle `tick` from the system clock. The divide value can be updated through a load handshake, and an update only takes effect at a full-period boundary, so no runt pulses are produced. It sits between control logic (counters, FSMs of later levels) and every consumer of a slow enable or clock.

---
 rtl/clk_div_ctrl.sv | 143 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable divided-clock / tick generator with run control and reloads applied only at period boundaries.
// Optional burst mode is compiled in when CLK_DIV_CTRL_BURST_EN is defined.
module clk_div_ctrl #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   div_val,
  input  logic               div_load,
  output logic               div_ack,
  output logic               clk_out,
  output logic               tick,
`ifdef CLK_DIV_CTRL_BURST_EN
  input  logic [BURST_W-1:0] burst_len,
  output logic               burst_done,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   cur_reg, cur_next;
  logic [WIDTH-1:0]   pend_reg, pend_next;
  logic [WIDTH-1:0]   cnt_reg, cnt_next;
  logic               pend_v_reg, pend_v_next;
  logic               clk_out_reg, clk_out_next;
  logic               tick_reg, tick_next;
  logic               ack_reg;
  logic [BURST_W-1:0] burst_len_eff, burst_cnt_reg, burst_cnt_next;
  logic               phase_end, boundary, burst_last, apply;

  // Without burst support the counter is always loaded with 0, i.e. continuous running.
`ifdef CLK_DIV_CTRL_BURST_EN
  assign burst_len_eff = burst_len;
`else
  assign burst_len_eff = '0;
`endif

  assign phase_end  = (cnt_reg == cur_reg - WIDTH'(1));
  assign boundary   = (state_reg != IDLE) && phase_end && !clk_out_reg;
  assign burst_last = (burst_cnt_reg == BURST_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_reg       <= WIDTH'(1);
      pend_reg      <= '0;
      pend_v_reg    <= 1'b0;
      cnt_reg       <= '0;
      clk_out_reg   <= 1'b0;
      tick_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      pend_reg      <= pend_next;
      pend_v_reg    <= pend_v_next;
      cnt_reg       <= cnt_next;
      clk_out_reg   <= clk_out_next;
      tick_reg      <= tick_next;
      ack_reg       <= div_load;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_next       = cur_reg;
    pend_next      = pend_reg;
    pend_v_next    = pend_v_reg;
    cnt_next       = cnt_reg;
    clk_out_next   = clk_out_reg;
    tick_next      = 1'b0;
    burst_cnt_next = burst_cnt_reg;
    apply          = 1'b0;

    case (state_reg)
      IDLE: begin
        clk_out_next = 1'b0;
        cnt_next     = '0;
        apply        = pend_v_reg;
        if (en) begin
          state_next     = RUN;
          clk_out_next   = 1'b1;
          tick_next      = 1'b1;
          burst_cnt_next = burst_len_eff;
        end
      end
      default: begin
        cnt_next = cnt_reg + WIDTH'(1);
        if (phase_end) begin
          cnt_next = '0;
          if (clk_out_reg) begin
            clk_out_next = 1'b0;
          end else begin
            // End of the low phase: the only point where the period may change or stop.
            apply = pend_v_reg;
            if (burst_cnt_reg != '0) burst_cnt_next = burst_cnt_reg - BURST_W'(1);
            if ((state_reg == STOP && !en) || burst_last) begin
              state_next   = IDLE;
              clk_out_next = 1'b0;
            end else begin
              clk_out_next = 1'b1;
              tick_next    = 1'b1;
            end
          end
        end
        if (state_next != IDLE) state_next = en ? RUN : STOP;
      end
    endcase

    if (apply) begin
      cur_next    = pend_reg;
      pend_v_next = 1'b0;
    end
    // A load in the same cycle as an apply lands after it, so it waits for the next boundary.
    if (div_load) begin
      pend_next   = (div_val == '0) ? WIDTH'(1) : div_val;
      pend_v_next = 1'b1;
    end
  end

`ifdef CLK_DIV_CTRL_BURST_EN
  logic burst_done_reg;

  always_ff @(posedge clk) begin
    if (rst) burst_done_reg <= 1'b0;
    else     burst_done_reg <= boundary && burst_last;
  end

  assign burst_done = burst_done_reg;
`endif

  assign div_ack = ack_reg;
  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic against a period-position model.
// Define CLK_DIV_CTRL_BURST_EN to also exercise burst mode.
module tb_clk_div_ctrl;
  localparam int WIDTH = 16;

  logic             clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic [7:0]       burst_len = '0;
  logic             div_ack, clk_out, tick, busy;
`ifdef CLK_DIV_CTRL_BURST_EN
  logic             burst_done;
`endif
  int n_checks = 0, n_fail = 0;

  clk_div_ctrl #(.WIDTH(WIDTH), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .div_ack(div_ack), .clk_out(clk_out), .tick(tick),
`ifdef CLK_DIV_CTRL_BURST_EN
    .burst_len(burst_len), .burst_done(burst_done),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: position inside the current period (0 .. 2*cur-1); high while pos < cur.
  int unsigned m_cur = 1, m_pend = 1, m_pos = 0, m_burst = 0;
  bit m_pend_v = 0, m_active = 0, m_stop = 0, m_ack = 0, m_done = 0;

  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_cur = 1; m_pend_v = 0; m_active = 0; m_pos = 0; m_ack = 0; m_stop = 0; m_burst = 0;
    end else begin
      m_ack = div_load;
      if (!m_active) begin
        if (m_pend_v) begin m_cur = m_pend; m_pend_v = 0; end
        if (en) begin m_active = 1; m_pos = 0; m_stop = 0; m_burst = burst_len; end
      end else if (m_pos == 2 * m_cur - 1) begin
        if (m_pend_v) begin m_cur = m_pend; m_pend_v = 0; end
        m_pos = 0;
        if (m_burst != 0) begin
          m_burst--;
          if (m_burst == 0) begin m_done = 1; m_active = 0; end
        end
        if (m_stop && !en) m_active = 0;
        m_stop = !en;
      end else begin
        m_pos++;
        m_stop = !en;
      end
      if (div_load) begin m_pend = (div_val == 0) ? 1 : div_val; m_pend_v = 1; end
    end
  end

  // Bit order: {clk_out, tick, busy, div_ack, burst_done}
  function automatic logic [4:0] obs_out();
`ifdef CLK_DIV_CTRL_BURST_EN
    return {clk_out, tick, busy, div_ack, burst_done};
`else
    return {clk_out, tick, busy, div_ack, 1'b0};
`endif
  endfunction

  function automatic logic [4:0] exp_out();
    return {m_active && (m_pos < m_cur), m_active && (m_pos == 0), m_active, m_ack, m_done};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; div_load = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_out() !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 00000", obs_out());
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_out() !== exp_out()) begin
      n_fail++; $display("FAIL reset_idle: got %b required %b", obs_out(), exp_out());
    end
  endtask

  task automatic test_div1();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL div1_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      n_checks++;
      if ({clk_out, tick, busy} !== {i % 2 == 0, i % 2 == 0, 1'b1}) begin
        n_fail++; $display("FAIL div1_wave cyc %0d: got %b required %b", i, {clk_out, tick, busy}, {i % 2 == 0, i % 2 == 0, 1'b1});
      end
    end
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL div1_drain cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_load5();
    div_val = 16'd5; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    n_checks++;
    if (div_ack !== 1'b1) begin n_fail++; $display("FAIL load5_ack: got %b required 1", div_ack); end
    @(negedge clk);
    n_checks++;
    if (div_ack !== 1'b0) begin n_fail++; $display("FAIL load5_ack_pulse: got %b required 0", div_ack); end
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL load5_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      n_checks++;
      if ({clk_out, tick} !== {(i % 10) < 5, i % 10 == 0}) begin
        n_fail++; $display("FAIL load5_wave cyc %0d: got %b required %b", i, {clk_out, tick}, {(i % 10) < 5, i % 10 == 0});
      end
    end
  endtask

  task automatic test_midload();
    bit found;
    int acks, gap;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL midload_sync cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      if (m_active && m_pos == 1) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midload_sync_timeout: got no high phase required one"); end
    div_val = 16'd3; div_load = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      div_load = 1'b0;
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL midload3_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
    end
    // Two loads inside one period of 3/3; only the second must take effect.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_active && m_pos == 0) found = 1;
    end
    acks = 0;
    for (int i = 0; i < 24; i++) begin
      div_load = (i == 0 || i == 2);
      div_val  = (i == 0) ? 16'd7 : 16'd2;
      @(negedge clk);
      if (div_ack === 1'b1) acks++;
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL double_load_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
    end
    div_load = 1'b0;
    n_checks++;
    if (acks != 2) begin n_fail++; $display("FAIL double_load_acks: got %0d required 2", acks); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1;
    end
    gap = 0;
    found = 0;
    for (int i = 1; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin gap = i; found = 1; end
    end
    n_checks++;
    if (gap != 4) begin n_fail++; $display("FAIL double_load_period: got %0d required 4", gap); end
  endtask

  task automatic test_stop();
    bit found;
    div_val = 16'd4; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL stop_sync cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      if (m_active && m_cur == 4 && m_pos == 0) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL stop_sync_timeout: got no period of 4 required one"); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL stop_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      n_checks++;
      if ({clk_out, busy} !== {i < 3, i < 7}) begin
        n_fail++; $display("FAIL stop_wave cyc %0d: got %b required %b", i, {clk_out, busy}, {i < 3, i < 7});
      end
    end
    en = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 0) en = 1'b0;
      if (i == 5) en = 1'b1;
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL rearm_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy cyc %0d: got %b required 1", i, busy); end
    end
  endtask

  task automatic test_zero_and_reset();
    bit found;
    logic prev;
    div_val = 16'd0; div_load = 1'b1;
    prev = clk_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      div_load = 1'b0;
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL zero_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      if (i >= 14) begin
        n_checks++;
        if (clk_out === prev) begin n_fail++; $display("FAIL zero_toggle cyc %0d: got %b required %b", i, clk_out, !prev); end
      end
      prev = clk_out;
    end
    div_val = 16'd6; div_load = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      div_load = 1'b0;
      if (m_active && m_cur == 6 && m_pos == 8) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL reset_sync_timeout: got no low phase required one"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_out() !== 5'b0) begin n_fail++; $display("FAIL mid_reset: got %b required 00000", obs_out()); end
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL random_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      if ($urandom_range(0, 19) == 0) en = !en;
      div_load = ($urandom_range(0, 14) == 0);
      div_val  = WIDTH'($urandom_range(0, 6));
      rst      = ($urandom_range(0, 399) == 0);
`ifdef CLK_DIV_CTRL_BURST_EN
      if ($urandom_range(0, 9) == 0) burst_len = 8'($urandom_range(0, 4));
`endif
    end
    rst = 1'b0; en = 1'b0; div_load = 1'b0; burst_len = '0;
    repeat (2) @(negedge clk);
  endtask

`ifdef CLK_DIV_CTRL_BURST_EN
  task automatic test_burst();
    int ticks;
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0; div_val = 16'd2; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    @(negedge clk);
    burst_len = 8'd3; en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_out() !== exp_out()) begin
        n_fail++; $display("FAIL burst_model cyc %0d: got %b required %b", i, obs_out(), exp_out());
      end
      if (i < 12 && tick === 1'b1) ticks++;
      if (i == 11) begin
        n_checks++;
        if ({busy, burst_done} !== 2'b10) begin n_fail++; $display("FAIL burst_last_cycle: got %b required 10", {busy, burst_done}); end
      end
      if (i == 12) begin
        n_checks++;
        if ({busy, burst_done} !== 2'b01) begin n_fail++; $display("FAIL burst_end: got %b required 01", {busy, burst_done}); end
        en = 1'b0;
      end
    end
    n_checks++;
    if (ticks != 3) begin n_fail++; $display("FAIL burst_ticks: got %0d required 3", ticks); end
    burst_len = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_div1();
    test_load5();
    test_midload();
    test_stop();
    test_zero_and_reset();
`ifdef CLK_DIV_CTRL_BURST_EN
    test_burst();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
